press_classifier: RTL

//  Consumes the one-cycle press pulse from the button debouncer and classifies each

---
 rtl/press_classifier_pkg.sv | 15 +
 rtl/press_classifier_if.sv | 26 ++
 rtl/press_classifier_window_timer.sv | 26 ++
 rtl/press_classifier.sv | 82 ++++++++
 4 files changed

// File: rtl/press_classifier_pkg.sv
// press_classifier_pkg: shared types and constants for the button press classifier.
//   state_t            FSM state encoding (IDLE / WAIT)
//   DEF_WINDOW_CYCLES  default double-press window (250 ms at CLK_HZ)
//   CLK_HZ             system clock frequency the defaults are sized for
package press_classifier_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam int CLK_HZ            = 100_000_000;
  localparam int DEF_WINDOW_CYCLES = 25_000_000;

endpackage

// File: rtl/press_classifier_if.sv
// press_classifier_if: press input and classified-event outputs of one button.
//   press         debounced press pulse into the classifier
//   single_press  1-cycle single-press event
//   double_press  1-cycle double-press event
//   busy          a sequence is pending
//   event_count   wrapping count of classified events
// Modports: master = press source / event consumer, slave = classifier.
interface press_classifier_if #(
  parameter int CNT_W = 8
);
  logic             press;
  logic             single_press;
  logic             double_press;
  logic             busy;
  logic [CNT_W-1:0] event_count;

  modport master (
    output press,
    input  single_press, double_press, busy, event_count
  );

  modport slave (
    input  press,
    output single_press, double_press, busy, event_count
  );
endinterface

// File: rtl/press_classifier_window_timer.sv
// window_timer: counts cycles of the double-press window.
//   clk, rst  clock, async active-high reset
//   clear     synchronous clear to 0 (priority over enable)
//   enable    advance count by one
//   tc        terminal count: count == WINDOW_CYCLES-1
module window_timer #(
  parameter int WINDOW_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);
  localparam int TW = $clog2(WINDOW_CYCLES + 1);

  logic [TW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + 1'b1;
  end

  assign tc = (count == TW'(WINDOW_CYCLES - 1));
endmodule

// File: rtl/press_classifier.sv
// press_classifier: classifies debounced press sequences as single or double presses.
//   clk, rst  clock, async active-high reset
//   bus       press_classifier_if.slave: press in; single_press, double_press,
//             busy, event_count out
// A press edge in IDLE opens a WINDOW_CYCLES window; a second edge inside it
// (including on the terminal cycle) is a double, otherwise timeout is a single.
module press_classifier
  import press_classifier_pkg::*;
#(
  parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
  parameter int CNT_W         = 8
) (
  input  logic               clk,
  input  logic               rst,
  press_classifier_if.slave  bus
);
  state_t           state, state_next;
  logic             press_q;
  logic             press_edge;
  logic             tc;
  logic             timer_clear, timer_en;
  logic             single_nxt, double_nxt;
  logic             single_q, double_q;
  logic [CNT_W-1:0] cnt;

  // Only the rising edge counts, so a held button is one press.
  assign press_edge = bus.press & ~press_q;

  always_comb begin
    state_next = state;
    single_nxt = 1'b0;
    double_nxt = 1'b0;
    case (state)
      ST_IDLE: if (press_edge) state_next = ST_WAIT;
      ST_WAIT: begin
        // Edge is checked first so a press on the terminal cycle is a double.
        if (press_edge) begin
          double_nxt = 1'b1;
          state_next = ST_IDLE;
        end else if (tc) begin
          single_nxt = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Timer held at 0 outside WAIT and cleared on the exit cycle, so it never
  // passes WINDOW_CYCLES-1 and starts from 0 for the next sequence.
  assign timer_clear = (state == ST_IDLE) | (state_next == ST_IDLE);
  assign timer_en    = (state == ST_WAIT);

  window_timer #(.WINDOW_CYCLES(WINDOW_CYCLES)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (timer_en),
    .tc     (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      press_q  <= 1'b0;
      single_q <= 1'b0;
      double_q <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= state_next;
      press_q  <= bus.press;
      single_q <= single_nxt;
      double_q <= double_nxt;
      if (single_nxt | double_nxt) cnt <= cnt + 1'b1;
    end
  end

  assign bus.single_press = single_q;
  assign bus.double_press = double_q;
  assign bus.busy         = (state == ST_WAIT);
  assign bus.event_count  = cnt;
endmodule
